// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller gating the CPU pipeline clock enable, with a one-shot
// breakpoint skip on resume and a free-running count of enabled cycles.
module cpu_run_ctrl #(
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  input  logic             cnt_clr,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic             step_done,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES);

  state_t     st;
  logic       skip;
  logic [7:0] step_left;
  logic       bp_match;

  // skip masks the breakpoint at the resume address until the first enabled cycle
  assign bp_match = bp_en && (pc == bp_addr) && !skip;
  assign state    = st;

  // Only halt_req, pc and the breakpoint compare reach cpu_en combinationally
  always_comb begin
    cpu_en = 1'b0;
    case (st)
      ST_RUN:  cpu_en = !halt_req && !bp_match;
      ST_STEP: cpu_en = !halt_req;
      default: cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= ST_HALT;
      skip      <= 1'b0;
      step_left <= 8'd0;
      bp_hit    <= 1'b0;
      step_done <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      step_done <= 1'b0;

      if (cpu_en)
        skip <= 1'b0;

      if (cnt_clr)
        cycle_cnt <= '0;
      else if (cpu_en)
        cycle_cnt <= cycle_cnt + CNT_W'(1);

      case (st)
        ST_HALT: begin
          if (run) begin
            st     <= ST_RUN;
            skip   <= 1'b1;
            bp_hit <= 1'b0;
          end else if (step) begin
            st        <= ST_STEP;
            step_left <= STEP_LOAD;
            skip      <= 1'b1;
            bp_hit    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt_req || bp_match) begin
            st     <= ST_HALT;
            bp_hit <= bp_match;
          end
        end
        ST_STEP: begin
          if (halt_req) begin
            st        <= ST_HALT;
            step_left <= 8'd0;
          end else begin
            step_left <= step_left - 8'd1;
            if (step_left == 8'd1) begin
              st        <= ST_HALT;
              step_done <= 1'b1;
            end
          end
        end
        default: st <= ST_HALT;
      endcase
    end
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL have parameter STEP_CYCLES, default 1, giving the number of enabled pipeline cycles per step command (legal range 1..255).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the enabled-cycle counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port run, input, 1 bit: one-cycle pulse requesting free-running execution.
REQ-006 The block SHALL have port step, input, 1 bit: one-cycle pulse requesting STEP_CYCLES enabled cycles.
REQ-007 The block SHALL have port halt_req, input, 1 bit: one-cycle pulse requesting immediate stop.
REQ-008 The block SHALL have port bp_en, input, 1 bit: breakpoint compare enable.
REQ-009 The block SHALL have port bp_addr, input, 32 bits: breakpoint fetch address.
REQ-010 The block SHALL have port pc, input, 32 bits: current IF-stage fetch address from the pipeline.
REQ-011 The block SHALL have port cnt_clr, input, 1 bit: one-cycle pulse clearing cycle_cnt.
REQ-012 The block SHALL have port cpu_en, output, 1 bit: pipeline clock enable (PC and all stage registers advance only when 1).
REQ-013 The block SHALL have port state, output, 2 bits: HALT=00, RUN=01, STEP=10.
REQ-014 The block SHALL have port bp_hit, output, 1 bit: sticky flag, breakpoint caused last stop.
REQ-015 The block SHALL have port step_done, output, 1 bit: one-cycle registered pulse when a step completes.
REQ-016 The block SHALL have port cycle_cnt, output, CNT_W bits: count of cycles with cpu_en=1.

Function
REQ-017 The block SHALL hold a registered FSM with states HALT, RUN, STEP; encoding 11 SHALL transition to HALT next cycle with cpu_en=0.
REQ-018 In HALT, cpu_en SHALL be 0; run SHALL move to RUN; step (without run) SHALL move to STEP; run and step together SHALL select RUN.
REQ-019 On accepting run or step from HALT, the block SHALL set an internal skip flag and clear bp_hit on the same edge.
REQ-020 bp_match SHALL be bp_en AND (pc == bp_addr) AND NOT skip, evaluated combinationally.
REQ-021 In RUN, cpu_en SHALL be combinationally 1 unless halt_req or bp_match is 1, in which case cpu_en SHALL be 0 that cycle and the next state SHALL be HALT.
REQ-022 A RUN-to-HALT transition caused by bp_match SHALL set bp_hit; one caused by halt_req alone SHALL leave bp_hit at 0.
REQ-023 step SHALL be ignored in RUN; run SHALL be ignored in RUN and STEP.
REQ-024 On entering STEP, a step counter SHALL load STEP_CYCLES; in STEP, cpu_en SHALL be 1 and the counter SHALL decrement each cycle.
REQ-025 When the step counter equals 1 in STEP, the next state SHALL be HALT and step_done SHALL pulse for exactly the following cycle.
REQ-026 Breakpoints SHALL NOT stop STEP; halt_req in STEP SHALL force cpu_en=0 that cycle, transition to HALT, and suppress step_done.
REQ-027 skip SHALL clear after the first cycle in which cpu_en=1, so a breakpoint at the resume address is ignored exactly once.
REQ-028 cycle_cnt SHALL increment by 1 on every edge where cpu_en=1, wrapping from all-ones to 0.
REQ-029 cnt_clr SHALL load cycle_cnt with 0, taking priority over a simultaneous increment.
REQ-030 The block SHALL have no combinational path from run, step, or cnt_clr to cpu_en.

Reset
REQ-031 While rstn=0, the block SHALL asynchronously force: state=HALT, cpu_en=0, bp_hit=0, step_done=0, cycle_cnt=0, skip=0, step counter=0.
REQ-032 After rstn deasserts, the block SHALL remain in HALT until a run or step pulse; reset mid-RUN or mid-STEP SHALL abort with no step_done.

Verification
REQ-033 Reset then run pulse, bp_en=0, 10 cycles -> state=01, cpu_en=1 from the cycle after run, cycle_cnt=10.
REQ-034 RUN with bp_en=1, bp_addr=0x0000_0010, pc stepping 0x0, 0x4, ..., 0x10 -> cpu_en=0 in the pc=0x10 cycle, state=00, bp_hit=1, cycle_cnt=4.
REQ-035 From REQ-034, run pulse with pc still 0x10 -> bp_hit clears, cpu_en=1 for the first cycle, no re-stop at 0x10.
REQ-036 STEP_CYCLES=3, step pulse -> exactly 3 cpu_en=1 cycles, then state=00 and one step_done pulse; second step pulse repeats, cycle_cnt=6.
REQ-037 halt_req in 2nd STEP cycle (STEP_CYCLES=3) -> cpu_en=0 that cycle, state=00, no step_done, cycle_cnt=1.
REQ-038 cycle_cnt preset near all-ones via run, wraps to 0; cnt_clr coincident with cpu_en=1 -> cycle_cnt=0; rstn low mid-RUN -> all outputs at reset values immediately.
